// File: rtl/idct_frame_sequencer.sv
// idct_frame_sequencer
// Frame scheduler ahead of the IDCT vector-rotation scaler. Queues per-frame
// IFFT length configs, counts the incoming sample stream into frames, and
// emits sop/eop plus a frame-stable fftpts_out. Adds a programmable idle gap
// between frames and applies ready/valid backpressure.
// Optional build macro: IDCT_SEQ_STATS_EN enables the frame_cnt counter and
// an internal saturating err_cnt. Without it, frame_cnt is tied to zero.
module idct_frame_sequencer #(
  parameter int wData     = 36,
  parameter int CFG_DEPTH = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [11:0]      cfg_fftpts,
  output logic             cfg_err,
  input  logic             sink_valid,
  output logic             sink_ready,
  input  logic [wData-1:0] sink_real,
  input  logic [wData-1:0] sink_imag,
  output logic             source_valid,
  input  logic             source_ready,
  output logic             source_sop,
  output logic             source_eop,
  output logic [wData-1:0] source_real,
  output logic [wData-1:0] source_imag,
  output logic [11:0]      fftpts_out,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  // Pointer / occupancy widths; the count needs one extra bit to represent "full".
  localparam int PW = (CFG_DEPTH > 1) ? $clog2(CFG_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(CFG_DEPTH);

  // Gap counter sized for GAP_CYC; unused (but harmless) when GAP_CYC is 0.
  localparam int GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q;
  logic [11:0]       cfg_mem [CFG_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              cfg_ready_q;
  logic              cfg_err_q;
  logic [11:0]       fftpts_q;
  logic [11:0]       sample_cnt_q;
  logic [GW-1:0]     gap_cnt_q;
  logic              src_valid_q;
  logic              src_sop_q;
  logic              src_eop_q;
  logic [wData-1:0]  src_real_q;
  logic [wData-1:0]  src_imag_q;

  logic cfg_legal;
  logic cfg_push;
  logic cfg_bad;
  logic cfg_pop;
  logic out_free;
  logic sink_rdy;
  logic accept;
  logic last_sample;

  // Handshake decode: config legality, FIFO push/pop and sample acceptance.
  always_comb begin
    cfg_legal   = (cfg_fftpts == 12'd128)  || (cfg_fftpts == 12'd256) ||
                  (cfg_fftpts == 12'd512)  || (cfg_fftpts == 12'd1024) ||
                  (cfg_fftpts == 12'd2048);
    cfg_push    = cfg_valid && cfg_ready_q && cfg_legal;
    cfg_bad     = cfg_valid && cfg_ready_q && !cfg_legal;
    // Output register can take a new sample when empty or being drained this cycle.
    out_free    = !src_valid_q || source_ready;
    // A new frame length is only loaded once the previous frame's last sample
    // has left (or is leaving) the output register, so fftpts_out stays stable.
    cfg_pop     = (state_q == IDLE) && (count_q != '0) && out_free;
    sink_rdy    = (state_q == RUN) && out_free;
    accept      = sink_valid && sink_rdy;
    last_sample = (sample_cnt_q == (fftpts_q - 12'd1));
    count_d     = count_q;
    case ({cfg_push, cfg_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Config storage: plain write port, no reset needed on the contents.
  always_ff @(posedge clk) begin
    if (cfg_push) begin
      cfg_mem[wr_ptr_q] <= cfg_fftpts;
    end
  end

  // Config FIFO write pointer, occupancy, registered ready and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      if (cfg_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      count_q     <= count_d;
      cfg_ready_q <= (count_d != DEPTH_C);
      cfg_err_q   <= cfg_bad;
    end
  end

  // Frame FSM plus the sink->source output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      fftpts_q     <= '0;
      sample_cnt_q <= '0;
      gap_cnt_q    <= '0;
      src_valid_q  <= 1'b0;
      src_sop_q    <= 1'b0;
      src_eop_q    <= 1'b0;
      src_real_q   <= '0;
      src_imag_q   <= '0;
    end else begin
      if (accept) begin
        src_valid_q <= 1'b1;
        src_sop_q   <= (sample_cnt_q == 12'd0);
        src_eop_q   <= last_sample;
        src_real_q  <= sink_real;
        src_imag_q  <= sink_imag;
      end else if (source_ready) begin
        src_valid_q <= 1'b0;
        src_sop_q   <= 1'b0;
        src_eop_q   <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (cfg_pop) begin
            fftpts_q     <= cfg_mem[rd_ptr_q];
            rd_ptr_q     <= rd_ptr_q + PW'(1);
            sample_cnt_q <= '0;
            state_q      <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            sample_cnt_q <= sample_cnt_q + 12'd1;
            if (last_sample) begin
              gap_cnt_q <= '0;
              state_q   <= (GAP_CYC > 0) ? GAP : IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign cfg_err      = cfg_err_q;
  assign sink_ready   = sink_rdy;
  assign source_valid = src_valid_q;
  assign source_sop   = src_sop_q;
  assign source_eop   = src_eop_q;
  assign source_real  = src_real_q;
  assign source_imag  = src_imag_q;
  assign fftpts_out   = fftpts_q;
  assign busy         = (state_q != IDLE) || (count_q != '0);

`ifdef IDCT_SEQ_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  // Statistics: completed frames (wrapping) and illegal configs (saturating).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (src_valid_q && src_eop_q && source_ready) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (cfg_err_q && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule
